// File: rtl/sdc_pkg.sv
// Shared types and constants for the SD/HPS request guard.
//   guard_state_t : request guard FSM states
//   ERR_*         : err_code values reported with xfer_err
//   SECTOR_BYTES  : bytes in one sector transfer
package sdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        XFER,
        DONE,
        FAULT
    } guard_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NOTRDY  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_SHORT   = 2'd3;

    localparam int         SECTOR_BYTES = 512;
    localparam logic [9:0] SECTOR_CNT   = 10'(SECTOR_BYTES);
    localparam logic [8:0] LAST_ADDR    = 9'(SECTOR_BYTES - 1);

endpackage

// File: rtl/sdc_wdog.sv
// Saturating watchdog counter.
//   clk     : clock
//   reset   : synchronous active-high reset
//   clr     : zero the counter (wins over en)
//   en      : count one per cycle until all ones
//   expired : counter has reached 2^TIMEOUT_W-1
module sdc_wdog #(
    parameter int TIMEOUT_W = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt;

    assign expired = &cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sdc_hps_req_guard.sv
// Request guard between the SD controller block-request side and the HPS
// sd_* block interface for two drives. One transfer in flight at a time,
// mount check before issue, ack watchdog and read byte counting.
//   CLK, RESET         : clock, synchronous active-high reset
//   req_rd/req_wr      : per-drive level requests; rising edge starts a transfer
//   req_lba            : per-drive LBA, captured on acceptance
//   drive_ready        : per-drive image mounted
//   hps_rd/hps_wr      : request to HPS, dropped on ack or timeout
//   hps_lba            : LBA to HPS, stable through the transfer
//   hps_ack            : per-drive ack from HPS
//   sd_buff_wr/addr    : HPS buffer write strobe and address
//   ctl_ack            : ack of the active drive, forwarded during XFER
//   busy               : transfer in flight
//   xfer_done          : one-cycle end-of-transfer pulse
//   xfer_err, err_code : sticky error flag and cause
module sdc_hps_req_guard
    import sdc_pkg::*;
#(
    parameter int TIMEOUT_W = 24,
    parameter int NDRV      = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [31:0] req_lba [2],
    input  logic [1:0]  drive_ready,
    output logic [1:0]  hps_rd,
    output logic [1:0]  hps_wr,
    output logic [31:0] hps_lba [2],
    input  logic [1:0]  hps_ack,
    input  logic        sd_buff_wr,
    input  logic [8:0]  sd_buff_addr,
    output logic [1:0]  ctl_ack,
    output logic        busy,
    output logic        xfer_done,
    output logic        xfer_err,
    output logic [1:0]  err_code
);

    if (NDRV != 2) begin : g_bad_ndrv
        $error("sdc_hps_req_guard supports exactly two drives");
    end

    guard_state_t state;
    logic         drv;
    logic         dir_rd;
    logic [31:0]  lba;
    logic [1:0]   req_rd_d;
    logic [1:0]   req_wr_d;
    logic         ack_d;
    logic [9:0]   bytecnt;
    logic         last_ok;

    logic [1:0]   rd_edge;
    logic [1:0]   wr_edge;
    logic         any0;
    logic         any1;
    logic         sel_drv;
    logic         sel_rd;
    logic         ack_cur;
    logic         ack_fall;
    logic         strobe;
    logic         wdog_clr;
    logic         wdog_en;
    logic         wdog_exp;

    assign rd_edge  = req_rd & ~req_rd_d;
    assign wr_edge  = req_wr & ~req_wr_d;
    assign any0     = rd_edge[0] | wr_edge[0];
    assign any1     = rd_edge[1] | wr_edge[1];
    // drive 0 wins a same-cycle tie; on the chosen drive a read beats a write
    assign sel_drv  = ~any0;
    assign sel_rd   = sel_drv ? rd_edge[1] : rd_edge[0];

    assign ack_cur  = hps_ack[drv];
    assign ack_fall = ack_d & ~ack_cur;
    assign strobe   = (state == XFER) && sd_buff_wr && ack_cur;

    // cleared on entry to WAIT_ACK (from ISSUE) and to XFER (ack seen)
    assign wdog_clr = (state == ISSUE) || ((state == WAIT_ACK) && ack_cur);
    assign wdog_en  = (state == WAIT_ACK) || (state == XFER);

    sdc_wdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
        .clk     (CLK),
        .reset   (RESET),
        .clr     (wdog_clr),
        .en      (wdog_en),
        .expired (wdog_exp)
    );

    always_comb begin
        ctl_ack = '0;
        if (state == XFER) begin
            ctl_ack[drv] = hps_ack[drv];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            drv        <= 1'b0;
            dir_rd     <= 1'b0;
            lba        <= '0;
            req_rd_d   <= '0;
            req_wr_d   <= '0;
            ack_d      <= 1'b0;
            bytecnt    <= '0;
            last_ok    <= 1'b0;
            hps_rd     <= '0;
            hps_wr     <= '0;
            hps_lba[0] <= '0;
            hps_lba[1] <= '0;
            busy       <= 1'b0;
            xfer_done  <= 1'b0;
            xfer_err   <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            // edges are tracked every cycle, so an edge seen while busy is lost
            req_rd_d  <= req_rd;
            req_wr_d  <= req_wr;
            ack_d     <= ack_cur;
            xfer_done <= 1'b0;

            if (strobe) begin
                if (bytecnt != SECTOR_CNT) begin
                    bytecnt <= bytecnt + 10'd1;
                end
                last_ok <= (sd_buff_addr == LAST_ADDR);
            end

            case (state)
                IDLE: begin
                    if (any0 || any1) begin
                        drv      <= sel_drv;
                        dir_rd   <= sel_rd;
                        lba      <= sel_drv ? req_lba[1] : req_lba[0];
                        xfer_err <= 1'b0;
                        err_code <= ERR_NONE;
                        if (!drive_ready[sel_drv]) begin
                            state     <= FAULT;
                            xfer_done <= 1'b1;
                            xfer_err  <= 1'b1;
                            err_code  <= ERR_NOTRDY;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    hps_lba[drv] <= lba;
                    if (dir_rd) begin
                        hps_rd[drv] <= 1'b1;
                    end else begin
                        hps_wr[drv] <= 1'b1;
                    end
                    bytecnt <= '0;
                    last_ok <= 1'b0;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_cur) begin
                        hps_rd <= '0;
                        hps_wr <= '0;
                        state  <= XFER;
                    end else if (wdog_exp) begin
                        hps_rd    <= '0;
                        hps_wr    <= '0;
                        state     <= FAULT;
                        busy      <= 1'b0;
                        xfer_done <= 1'b1;
                        xfer_err  <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                    end
                end
                XFER: begin
                    if (ack_fall) begin
                        busy      <= 1'b0;
                        xfer_done <= 1'b1;
                        if (!dir_rd || ((bytecnt == SECTOR_CNT) && last_ok)) begin
                            state <= DONE;
                        end else begin
                            state    <= FAULT;
                            xfer_err <= 1'b1;
                            err_code <= ERR_SHORT;
                        end
                    end else if (wdog_exp && ack_cur) begin
                        state     <= FAULT;
                        busy      <= 1'b0;
                        xfer_done <= 1'b1;
                        xfer_err  <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                    end
                end
                DONE, FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
